// File: rtl/phi2_pkg.sv
// Shared types and constants for the phi2 clock generator.
package phi2_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] to_cnt(input int value);
        return value[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/phi2_gen_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clk domain.
module sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/phi2_gen.sv
// 65xx phi2 bus clock generator with CPU reset sequencing after PLL lock.
// Define PHI2_STRETCH_EN to allow stretch_req to extend the phi2-high phase.
module phi2_gen
    import phi2_pkg::*;
#(
    parameter int LO_CYCLES     = 5,
    parameter int HI_CYCLES     = 5,
    parameter int LATCH_AT      = 3,
    parameter int RESET_PERIODS = 16,
    parameter int MAX_STRETCH   = 15
) (
    input  logic clk,
    input  logic resetn,
    input  logic pll_locked,
    input  logic stretch_req,
    output logic phi2,
    output logic phi2_rise_stb,
    output logic phi2_fall_stb,
    output logic latch_stb,
    output logic cpu_resetn,
    output logic stretching
);

    localparam logic [CNT_W-1:0] LO_LAST   = to_cnt(LO_CYCLES - 1);
    localparam logic [CNT_W-1:0] HI_LAST   = to_cnt(HI_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_CNT = to_cnt(LATCH_AT);
    localparam logic [CNT_W-1:0] PER_LAST  = to_cnt(RESET_PERIODS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] per_cnt;
    logic             lock_s;
    logic             draining;
    logic             lo_last;
    logic             hi_nom_end;
    logic             hi_last;
    logic             lock_lost;

`ifdef PHI2_STRETCH_EN
    localparam logic [CNT_W-1:0] ST_MAX = to_cnt(MAX_STRETCH);

    logic [CNT_W-1:0] st_cnt;
    logic             extend;
`else
    logic unused_stretch;

    assign unused_stretch = stretch_req ^ (MAX_STRETCH > 255);
    assign stretching     = 1'b0;
`endif

    sync2 u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_locked),
        .q      (lock_s)
    );

    // draining marks a high phase that must finish before dropping to WAIT_LOCK
    always_comb begin
        cnt_inc    = cnt + 1'b1;
        lo_last    = !phi2 && (cnt == LO_LAST);
        hi_nom_end = phi2 && (cnt >= HI_LAST);
        lock_lost  = !lock_s || draining;
`ifdef PHI2_STRETCH_EN
        extend     = hi_nom_end && stretch_req && (st_cnt < ST_MAX);
        hi_last    = hi_nom_end && !extend;
`else
        hi_last    = hi_nom_end;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_WAIT_LOCK;
            phi2          <= 1'b0;
            phi2_rise_stb <= 1'b0;
            phi2_fall_stb <= 1'b0;
            latch_stb     <= 1'b0;
            cpu_resetn    <= 1'b0;
            cnt           <= '0;
            per_cnt       <= '0;
            draining      <= 1'b0;
`ifdef PHI2_STRETCH_EN
            st_cnt        <= '0;
            stretching    <= 1'b0;
`endif
        end else begin
            phi2_rise_stb <= 1'b0;
            phi2_fall_stb <= 1'b0;
            latch_stb     <= 1'b0;

            unique case (state)
                ST_WAIT_LOCK: begin
                    phi2       <= 1'b0;
                    cpu_resetn <= 1'b0;
                    cnt        <= '0;
                    per_cnt    <= '0;
                    draining   <= 1'b0;
                    if (lock_s) begin
                        state     <= ST_HOLD;
                        latch_stb <= (LATCH_CNT == '0);
                    end
                end

                ST_HOLD, ST_RUN: begin
                    if (lock_lost) begin
                        cpu_resetn <= 1'b0;
                        per_cnt    <= '0;
                    end else if (state == ST_RUN) begin
                        cpu_resetn <= 1'b1;
                    end

                    if (!phi2) begin
                        if (!lock_s) begin
                            state <= ST_WAIT_LOCK;
                            cnt   <= '0;
                        end else if (lo_last) begin
                            phi2          <= 1'b1;
                            cnt           <= '0;
                            phi2_rise_stb <= 1'b1;
                        end else begin
                            cnt       <= cnt_inc;
                            latch_stb <= (cnt_inc == LATCH_CNT);
                        end
                    end else begin
                        if (!lock_s) begin
                            draining <= 1'b1;
                        end
`ifdef PHI2_STRETCH_EN
                        if (extend) begin
                            st_cnt     <= st_cnt + 1'b1;
                            stretching <= 1'b1;
                        end else
`endif
                        if (hi_last) begin
                            phi2          <= 1'b0;
                            cnt           <= '0;
                            phi2_fall_stb <= 1'b1;
`ifdef PHI2_STRETCH_EN
                            st_cnt        <= '0;
                            stretching    <= 1'b0;
`endif
                            if (lock_lost) begin
                                state    <= ST_WAIT_LOCK;
                                draining <= 1'b0;
                            end else begin
                                latch_stb <= (LATCH_CNT == '0);
                                // The final counted fall releases the CPU on the same edge
                                if (state == ST_HOLD) begin
                                    per_cnt <= per_cnt + 1'b1;
                                    if (per_cnt == PER_LAST) begin
                                        state      <= ST_RUN;
                                        cpu_resetn <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                default: state <= ST_WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_phi2_gen.sv
// Directed self-checking bench for phi2_gen at default parameters.
// Stretch checks run when PHI2_STRETCH_EN is defined, otherwise stretch_req must be ignored.
module tb_phi2_gen;

    logic clk = 1'b0;
    logic resetn;
    logic pll_locked;
    logic stretch_req;
    logic phi2;
    logic phi2_rise_stb;
    logic phi2_fall_stb;
    logic latch_stb;
    logic cpu_resetn;
    logic stretching;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    phi2_gen dut (
        .clk           (clk),
        .resetn        (resetn),
        .pll_locked    (pll_locked),
        .stretch_req   (stretch_req),
        .phi2          (phi2),
        .phi2_rise_stb (phi2_rise_stb),
        .phi2_fall_stb (phi2_fall_stb),
        .latch_stb     (latch_stb),
        .cpu_resetn    (cpu_resetn),
        .stretching    (stretching)
    );

    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic rst_v, input logic lock_v, input logic str_v);
        resetn      = rst_v;
        pll_locked  = lock_v;
        stretch_req = str_v;
    endtask

    // Advance to 1 ns after the c-th rising edge
    task automatic goto_cycle(input int c);
        if (cyc < c) begin
            while (cyc < c) begin
                @(posedge clk);
                cyc++;
            end
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_phi2"}, phi2, 1'b0);
        check_output({tag, "_rise"}, phi2_rise_stb, 1'b0);
        check_output({tag, "_fall"}, phi2_fall_stb, 1'b0);
        check_output({tag, "_latch"}, latch_stb, 1'b0);
        check_output({tag, "_cpu_resetn"}, cpu_resetn, 1'b0);
        check_output({tag, "_stretching"}, stretching, 1'b0);
    endtask

    // Lock seen after edge d+1 reaches the FSM at edge d+3, where the low phase starts
    task automatic check_hold_run(input int d);
        int pos;
        for (int t = 0; t <= 165; t++) begin
            pos = t % 10;
            goto_cycle(d + 3 + t);
            check_output("seq_phi2", phi2, pos >= 5);
            check_output("seq_rise", phi2_rise_stb, pos == 5);
            check_output("seq_fall", phi2_fall_stb, (pos == 0) && (t >= 10));
            check_output("seq_latch", latch_stb, pos == 3);
            check_output("seq_cpu_resetn", cpu_resetn, t >= 160);
            check_output("seq_stretching", stretching, 1'b0);
        end
    endtask

    initial begin
        int d;
        int l;
        int a;

        apply_stimulus(1'b0, 1'b0, 1'b0);
        #3;
        check_quiet("reset");

        goto_cycle(2);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        goto_cycle(4);
        check_quiet("no_lock");

        goto_cycle(5);
        d = cyc;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        goto_cycle(d + 1);
        check_output("sync_phi2_a", phi2, 1'b0);
        goto_cycle(d + 2);
        check_output("sync_phi2_b", phi2, 1'b0);
        check_output("sync_rise_b", phi2_rise_stb, 1'b0);
        check_hold_run(d);

        l = d + 3 + 176;
        goto_cycle(l);
        check_output("drop_pre_phi2", phi2, 1'b1);
        check_output("drop_pre_cpu_resetn", cpu_resetn, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        goto_cycle(l + 2);
        check_output("drop2_cpu_resetn", cpu_resetn, 1'b1);
        check_output("drop2_phi2", phi2, 1'b1);
        goto_cycle(l + 3);
        check_output("drop3_cpu_resetn", cpu_resetn, 1'b0);
        check_output("drop3_phi2", phi2, 1'b1);
        check_output("drop3_fall", phi2_fall_stb, 1'b0);
        goto_cycle(l + 4);
        check_output("drop4_phi2", phi2, 1'b0);
        check_output("drop4_fall", phi2_fall_stb, 1'b1);
        check_output("drop4_cpu_resetn", cpu_resetn, 1'b0);
        for (int t = 5; t <= 20; t++) begin
            goto_cycle(l + t);
            check_quiet("drop_idle");
        end

        d = cyc;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_hold_run(d);

        a = d + 3 + 177;
        goto_cycle(a);
        check_output("arst_pre_phi2", phi2, 1'b1);
        check_output("arst_pre_cpu_resetn", cpu_resetn, 1'b1);
        #2;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        #1;
        check_quiet("arst_now");
        goto_cycle(a + 2);
        check_quiet("arst_held");

        goto_cycle(a + 3);
        d = cyc;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        goto_cycle(d + 8);
        check_output("rst2_rise", phi2_rise_stb, 1'b1);
        check_output("rst2_phi2", phi2, 1'b1);

`ifdef PHI2_STRETCH_EN
        goto_cycle(d + 12);
        check_output("st_pre_phi2", phi2, 1'b1);
        check_output("st_pre_stretching", stretching, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        for (int t = 13; t <= 16; t++) begin
            goto_cycle(d + t);
            check_output("st_phi2", phi2, 1'b1);
            check_output("st_stretching", stretching, 1'b1);
            check_output("st_fall", phi2_fall_stb, 1'b0);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0);
        goto_cycle(d + 17);
        check_output("st_end_phi2", phi2, 1'b0);
        check_output("st_end_fall", phi2_fall_stb, 1'b1);
        check_output("st_end_stretching", stretching, 1'b0);
        goto_cycle(d + 18);
        check_output("st_end_fall_once", phi2_fall_stb, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1);

        goto_cycle(d + 22);
        check_output("cap_rise", phi2_rise_stb, 1'b1);
        goto_cycle(d + 26);
        check_output("cap_nominal_stretching", stretching, 1'b0);
        for (int t = 27; t <= 41; t++) begin
            goto_cycle(d + t);
            check_output("cap_phi2", phi2, 1'b1);
            check_output("cap_stretching", stretching, 1'b1);
        end
        goto_cycle(d + 42);
        check_output("cap_end_phi2", phi2, 1'b0);
        check_output("cap_end_fall", phi2_fall_stb, 1'b1);
        check_output("cap_end_stretching", stretching, 1'b0);
        goto_cycle(d + 47);
        check_output("cap2_rise", phi2_rise_stb, 1'b1);
        goto_cycle(d + 66);
        check_output("cap2_phi2", phi2, 1'b1);
        check_output("cap2_stretching", stretching, 1'b1);
        goto_cycle(d + 67);
        check_output("cap2_end_phi2", phi2, 1'b0);
        check_output("cap2_end_fall", phi2_fall_stb, 1'b1);
`else
        goto_cycle(d + 9);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        goto_cycle(d + 12);
        check_output("nost_phi2", phi2, 1'b1);
        check_output("nost_stretching_a", stretching, 1'b0);
        goto_cycle(d + 13);
        check_output("nost_end_phi2", phi2, 1'b0);
        check_output("nost_end_fall", phi2_fall_stb, 1'b1);
        check_output("nost_stretching_b", stretching, 1'b0);
        goto_cycle(d + 18);
        check_output("nost_rise", phi2_rise_stb, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phi2_gen.md
Name: phi2_gen

Overview:
- Sits directly downstream of the PLL; runs on its fast output clock and consumes its lock indication.
- Generates the 65xx CPU bus clock phi2 as a registered output, plus single-cycle strobes that downstream bus logic uses at phase edges and the address-latch point.
- Holds the CPU in reset until the PLL has locked and a set number of phi2 periods have elapsed.
- Optionally stretches phi2-high for slow devices.

Parameters:
- LO_CYCLES, 5: fast cycles in phi2-low phase; legal range 2..255.
- HI_CYCLES, 5: fast cycles in nominal phi2-high phase; legal range 2..255.
- LATCH_AT, 3: low-phase count value at which latch_stb fires; must be < LO_CYCLES.
- RESET_PERIODS, 16: complete phi2 periods that cpu_resetn is held low after lock; legal range 1..255.
- MAX_STRETCH, 15: maximum extra fast cycles added to one high phase; legal range 0..255.

Ports:
- clk, input, 1: fast clock from the PLL.
- resetn, input, 1: asynchronous, active-low reset.
- pll_locked, input, 1: PLL lock; asynchronous to clk, synchronised internally.
- stretch_req, input, 1: request to extend the current phi2-high phase.
- phi2, output, 1: CPU bus clock, registered.
- phi2_rise_stb, output, 1: pulse in the first cycle phi2 reads 1.
- phi2_fall_stb, output, 1: pulse in the first cycle phi2 reads 0 after a high phase.
- latch_stb, output, 1: pulse in the low-phase cycle where count == LATCH_AT.
- cpu_resetn, output, 1: active-low CPU reset.
- stretching, output, 1: high while phi2-high is held beyond HI_CYCLES.

Behaviour:
- Reset values while resetn = 0: all outputs 0; state = WAIT_LOCK; all counters 0; both synchroniser flops 0.
- pll_locked passes through a 2-flop synchroniser to give lock_s. Latency from input to lock_s is 2 clk cycles.
- States:
  - WAIT_LOCK: phi2 = 0; cpu_resetn = 0; no strobes. When lock_s = 1, go to HOLD and restart the low phase with cnt = 0.
  - HOLD: phi2 toggles normally; cpu_resetn = 0; per_cnt increments at each phi2 falling edge. When per_cnt reaches RESET_PERIODS, go to RUN. cpu_resetn goes 1 in the same cycle as that phi2_fall_stb.
  - RUN: phi2 toggles normally; cpu_resetn = 1.
- Phase counter cnt is 8 bits.
  - Low phase: cnt runs 0..LO_CYCLES-1 with phi2 = 0. At LO_CYCLES-1: next phi2 = 1, cnt = 0.
  - High phase: cnt runs 0..HI_CYCLES-1 with phi2 = 1. At HI_CYCLES-1 with no stretch: next phi2 = 0, cnt = 0.
- Nominal period is LO_CYCLES + HI_CYCLES fast cycles: 10 cycles, i.e. 24 MHz at 240 MHz.
- Strobes are registered and coincide with the first cycle of the new phase. latch_stb is high in the cycle where phi2 = 0 and cnt == LATCH_AT.
- Strobes fire in HOLD and RUN; none fire in WAIT_LOCK.
- Lock loss (lock_s = 0 in HOLD or RUN):
  - cpu_resetn goes 0 on the next edge.
  - If phi2 = 1, the high phase completes, including any active stretch, and phi2_fall_stb is emitted; the block then enters WAIT_LOCK.
  - If phi2 = 0, it enters WAIT_LOCK immediately.
  - per_cnt is cleared.
- Lock regained in the same cycle as completion: the block still passes through WAIT_LOCK for at least 1 cycle.
- Asynchronous reset mid-phase forces the reset values immediately. No completion of the current phase is guaranteed.

Optional Feature:
- Macro: PHI2_STRETCH_EN.
- Defined:
  - When phi2 = 1, cnt >= HI_CYCLES-1, stretch_req = 1 and st_cnt < MAX_STRETCH, phi2 stays high and st_cnt increments.
  - stretching = 1 in each cycle beyond the nominal high length.
  - At MAX_STRETCH, phi2 falls regardless of stretch_req.
  - st_cnt clears at the falling edge.
  - The low phase is never stretched.
- Undefined: stretch_req is ignored; stretching is tied 0; st_cnt and its logic are absent.

Decomposition:
- Package phi2_pkg holds:
  - state encoding constants ST_WAIT_LOCK, ST_HOLD, ST_RUN;
  - counter width constant CNT_W = 8.
- One sub-module: sync2, a 2-flop synchroniser with async active-low reset, used for pll_locked.

Test Plan:
- Defaults; release resetn, raise pll_locked at cycle 10 -> phi2 stays 0 until cycle 12. First phi2_rise_stb at cycle 17. Period 10 cycles with 5 high and 5 low.
- Defaults; count falls after lock -> cpu_resetn goes 1 with the 16th phi2_fall_stb and stays 1. latch_stb occurs exactly once per period, 3 cycles after each phi2_fall_stb.
- PHI2_STRETCH_EN; hold stretch_req = 1 for 4 cycles from high-phase cnt = 4 -> high phase lasts 9 cycles; stretching is high for 4 cycles; fall strobe fires once.
- PHI2_STRETCH_EN; stretch_req held at 1 permanently -> high phase capped at 20 cycles (5 + 15); the next high phase also caps at 20.
- Drop pll_locked in RUN during high-phase cnt = 1 -> cpu_resetn goes 0 within 3 cycles; phi2 completes its high phase and then stays 0; no further strobes. Re-raising lock repeats the 16-period hold.
- Assert resetn = 0 mid high phase -> phi2, strobes and cpu_resetn go 0 asynchronously with no clock edge required.
